cbm2_cycle_sched: RTL and testbench

Central bus-slot scheduler for the CBM-II core. It divides clk_sys into a repeating frame of numbered slots: EXT0-3, CPU0-7 and VID0-5. From that frame it produces the CPU, I/O, VIC-II, CRTC and pixel enables, the phi phase, the SDRAM refresh request and pause gating. It also arbitrates the external (ioctl) requester onto the EXT slots through a req/ack handshake. It replaces the ad-hoc cycle logic in the top level, and its outputs feed the buslogic, the CPU and all peripherals.

---
 rtl/cbm2_cycle_sched_pkg.sv | 20 ++
 rtl/cbm2_cycle_sched_if.sv | 8 +
 rtl/cbm2_cycle_sched_ext_arb.sv | 44 ++++
 rtl/cbm2_cycle_sched.sv | 104 ++++++++++
 tb/tb_cbm2_cycle_sched.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cbm2_cycle_sched_pkg.sv
// Shared slot numbering, strobe slot positions and ext arbiter states
// for the CBM-II bus-slot scheduler.
package cbm2_sched_pkg;

  // Slot numbering within one frame; Professional frames end at VID3.
  typedef enum logic [4:0] {
    EXT0, EXT1, EXT2, EXT3,
    CPU0, CPU1, CPU2, CPU3, CPU4, CPU5, CPU6, CPU7,
    VID0, VID1, VID2, VID3, VID4, VID5
  } sys_slot_t;

  localparam logic [4:0] SLOT_IO_N = 5'd6;
  localparam logic [4:0] SLOT_CPU  = 5'd7;
  localparam logic [4:0] SLOT_IO_P = 5'd8;
  localparam logic [4:0] SLOT_CRTC = 5'd11;
  localparam logic [4:0] SLOT_VIC  = 5'd15;

  typedef enum logic {EXT_IDLE, EXT_BUSY} ext_state_t;

endpackage

// File: rtl/cbm2_cycle_sched_if.sv
// External requester handshake: level request, one-clock completion ack.
interface cbm2_cycle_sched_if;
  logic ext_req;
  logic ext_ack;

  modport master (output ext_req, input ext_ack);
  modport slave  (input ext_req, output ext_ack);
endinterface

// File: rtl/cbm2_cycle_sched_ext_arb.sv
// Ext window arbiter: grabs the EXT0..EXT3 window when a request is
// pending at an open slot 0, and acks on the fourth clock of the window.
module cbm2_ext_arb
  import cbm2_sched_pkg::*;
(
  input  logic clk_sys,
  input  logic reset,
  input  logic ext_req,
  input  logic io_win,   // io_cycle qualified with slot 0
  output logic ext_ack
);

  ext_state_t state;
  logic [1:0] tmr;

  // Window FSM; ack is registered so it is high exactly while tmr==3.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= EXT_IDLE;
      tmr     <= 2'd0;
      ext_ack <= 1'b0;
    end else begin
      case (state)
        EXT_IDLE: begin
          ext_ack <= 1'b0;
          if (ext_req && io_win) begin
            state <= EXT_BUSY;
            tmr   <= 2'd0;
          end
        end
        EXT_BUSY: begin
          tmr     <= tmr + 2'd1;
          ext_ack <= (tmr == 2'd2);
          if (tmr == 2'd3) state <= EXT_IDLE;
        end
        default: begin
          state   <= EXT_IDLE;
          ext_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cbm2_cycle_sched.sv
// CBM-II bus-slot scheduler: frame counter, phi phase, refresh/pause
// gating and the per-slot enables for CPU, I/O, video and pixels.
module cbm2_cycle_sched
  import cbm2_sched_pkg::*;
#(
  parameter int SLOTS_B  = 18,
  parameter int SLOTS_P  = 16,
  parameter int RFSH_DIV = 8
)(
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      model,
  input  logic                      turbo,
  input  logic                      slow_cs,
  input  logic                      copro_en,
  input  logic                      pause,
  cbm2_cycle_sched_if.slave         ext,
  output logic [4:0]                slot,
  output logic                      phase,
  output logic                      cpu_cycle,
  output logic                      vid_cycle,
  output logic                      io_cycle,
  output logic                      en_cpu,
  output logic                      en_io_n,
  output logic                      en_io_p,
  output logic                      en_vic,
  output logic                      en_crtc,
  output logic                      en_pixel,
  output logic                      refresh,
  output logic                      paused
);

  localparam int RW = (RFSH_DIV > 1) ? $clog2(RFSH_DIV) : 1;

  logic [4:0]    cnt;
  logic [4:0]    end_slot;
  logic [RW-1:0] rfsh_cnt;
  logic          sys_en;
  logic [1:0]    pixdiv;
  logic          wrap, over, fast, ph_ok;

  assign end_slot = model ? 5'(SLOTS_B - 1) : 5'(SLOTS_P - 1);
  assign wrap     = (cnt == end_slot);
  // Only reachable for one clock after a Business->Professional switch.
  assign over     = (cnt > end_slot);

  // Frame counter; phase, refresh divider and pause sample move on real wraps only.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt      <= 5'd0;
      phase    <= 1'b0;
      rfsh_cnt <= '0;
      sys_en   <= 1'b0;
    end else if (over) begin
      cnt <= 5'd0;
    end else if (wrap) begin
      cnt      <= 5'd0;
      phase    <= ~phase;
      rfsh_cnt <= rfsh_cnt + 1'b1;
      if (rfsh_cnt == '0) sys_en <= ~pause;
    end else begin
      cnt <= cnt + 5'd1;
    end
  end

  // Pixel divider, realigned to the frame and held while frozen.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                            pixdiv <= 2'd0;
    else if (!sys_en || slot == end_slot) pixdiv <= 2'd0;
    else                                  pixdiv <= pixdiv + 2'd1;
  end

  assign refresh  = wrap && (rfsh_cnt == '0);
  assign slot     = sys_en ? cnt : 5'd0;
  assign paused   = ~sys_en;
  assign en_pixel = (pixdiv == 2'd3);

  // In 1 MHz mode the CPU only owns its slots in phase 1.
  assign fast  = model | (turbo & ~slow_cs);
  assign ph_ok = phase | fast;

  assign en_io_n = (slot == SLOT_IO_N) && ph_ok;
  assign en_cpu  = (slot == SLOT_CPU)  && ph_ok;
  assign en_io_p = (slot == SLOT_IO_P) && ph_ok;
  assign en_crtc = (slot == SLOT_CRTC);
  assign en_vic  = (slot == SLOT_VIC);

  assign cpu_cycle = ((slot >= 5'(CPU0)) && (slot <= 5'(CPU3)) && ph_ok) ||
                     ((slot >= 5'(CPU4)) && (slot <= 5'(CPU7)) && copro_en) ||
                     ((slot <= 5'(EXT3)) && copro_en && !phase);
  assign vid_cycle = (slot >= 5'(VID0));
  // EXT slots are lost to the copro in phase 0 and to refresh in divider slot 1.
  assign io_cycle  = (slot <= 5'(EXT3)) && (rfsh_cnt != RW'(1)) &&
                     (phase || !copro_en);

  cbm2_ext_arb u_ext_arb (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ext_req (ext.ext_req),
    .io_win  (io_cycle && (slot == 5'(EXT0))),
    .ext_ack (ext.ext_ack)
  );

endmodule

// File: tb/tb_cbm2_cycle_sched.sv
// Directed bench for cbm2_cycle_sched: a vector table of per-cycle output
// snapshots, then hand sequences for pause, ext windows and reset abort.
module tb_cbm2_cycle_sched;

  logic clk_sys = 1'b0;
  logic reset;
  logic model, turbo, slow_cs, copro_en, pause;
  logic [4:0] slot;
  logic phase, cpu_cycle, vid_cycle, io_cycle;
  logic en_cpu, en_io_n, en_io_p, en_vic, en_crtc, en_pixel, refresh, paused;

  cbm2_cycle_sched_if ext_bus ();

  cbm2_cycle_sched dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .model     (model),
    .turbo     (turbo),
    .slow_cs   (slow_cs),
    .copro_en  (copro_en),
    .pause     (pause),
    .ext       (ext_bus),
    .slot      (slot),
    .phase     (phase),
    .cpu_cycle (cpu_cycle),
    .vid_cycle (vid_cycle),
    .io_cycle  (io_cycle),
    .en_cpu    (en_cpu),
    .en_io_n   (en_io_n),
    .en_io_p   (en_io_p),
    .en_vic    (en_vic),
    .en_crtc   (en_crtc),
    .en_pixel  (en_pixel),
    .refresh   (refresh),
    .paused    (paused)
  );

  always #5 clk_sys = ~clk_sys;

  // slot | phase paused refresh | en_cpu en_io_n en_io_p | en_crtc en_vic en_pixel | cpu vid io
  logic [16:0] ow;
  assign ow = {slot, phase, paused, refresh, en_cpu, en_io_n, en_io_p,
               en_crtc, en_vic, en_pixel, cpu_cycle, vid_cycle, io_cycle};

  localparam logic [16:0] RST_WORD = {5'd0, 12'b010_000_000_001};

  typedef struct {
    int         cyc;
    logic [4:0] in;     // model turbo slow_cs copro_en pause
    logic [4:0] slot;
    logic [11:0] flags;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic addv(input int c, input logic [4:0] in, input int s, input logic [11:0] f);
    vec_t v;
    v.cyc = c; v.in = in; v.slot = 5'(s); v.flags = f;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input logic [4:0] v);
    {model, turbo, slow_cs, copro_en, pause} = v;
  endtask

  // One clock: advance past posedge, sample point is just after the negedge.
  task automatic step();
    @(posedge clk_sys);
    cyc++;
    @(negedge clk_sys);
    #1;
  endtask

  initial begin
    int acks, a0, a1, strobes;
    reset = 1'b1;
    ext_bus.ext_req = 1'b0;
    set_in(5'b10000);

    // Business frames: wrap at 17, run from 18 in phase 1
    addv(  0, 5'b10000,  0, 12'b010_000_000_001);
    addv( 17, 5'b10000,  0, 12'b011_000_000_001);
    addv( 18, 5'b10000,  0, 12'b100_000_000_000);
    addv( 24, 5'b10000,  6, 12'b100_010_000_100);
    addv( 25, 5'b10000,  7, 12'b100_100_001_100);
    addv( 26, 5'b10000,  8, 12'b100_001_000_000);
    addv( 29, 5'b10000, 11, 12'b100_000_101_000);
    addv( 33, 5'b10000, 15, 12'b100_000_011_010);
    addv( 35, 5'b10000, 17, 12'b100_000_000_010);
    addv( 36, 5'b10000,  0, 12'b000_000_000_001);
    addv( 37, 5'b10010,  1, 12'b000_000_000_100);
    addv( 43, 5'b10010,  7, 12'b000_100_001_100);
    addv( 46, 5'b10010, 10, 12'b000_000_000_100);
    addv( 52, 5'b10000, 16, 12'b000_000_000_010);
    // model drops to 0 during cnt==16: forced wrap, phase stays 0
    addv( 53, 5'b00000,  0, 12'b000_000_000_001);
    addv( 60, 5'b00000,  7, 12'b000_000_000_000);
    addv( 76, 5'b00000,  7, 12'b100_100_001_100);
    addv( 92, 5'b01000,  7, 12'b000_100_001_100);
    addv(108, 5'b01000,  7, 12'b100_100_001_100);
    addv(122, 5'b01000,  5, 12'b000_000_000_100);
    addv(124, 5'b01100,  7, 12'b000_000_001_000);
    addv(140, 5'b01100,  7, 12'b100_100_001_100);
    addv(164, 5'b01100, 15, 12'b001_000_011_010);
    addv(165, 5'b01100,  0, 12'b100_000_000_000);

    @(negedge clk_sys); #1;
    chk("reset_hold", 32'(ow), 32'(RST_WORD));
    reset = 1'b0;
    cyc = 0;

    foreach (tbl[i]) begin
      set_in(tbl[i].in);
      while (cyc < tbl[i].cyc) step();
      #1;
      chk($sformatf("vec%0d_cyc%0d", i, tbl[i].cyc), 32'(ow), 32'({tbl[i].slot, tbl[i].flags}));
    end

    // Pause request only lands on the next refresh-divider wrap
    set_in(5'b00001);
    while (cyc < 292) step();
    chk("pause_pre_wrap", 32'({refresh, paused}), 32'(2'b10));
    step();
    chk("pause_taken", 32'({paused, slot}), 32'({1'b1, 5'd0}));
    strobes = 0;
    while (cyc < 420) begin
      step();
      if (cyc == 300) pause = 1'b0;
      strobes += int'(en_cpu | en_io_n | en_io_p | en_crtc | en_vic | en_pixel);
    end
    chk("strobes_while_paused", 32'(strobes), 32'd0);
    chk("pause_hold_to_wrap", 32'({paused, refresh}), 32'(2'b11));
    step();
    chk("resume", 32'({paused, phase, slot}), 32'({1'b0, 1'b1, 5'd0}));

    // Ext window, copro absent: rfsh_cnt==1 frame skipped, req drop mid-window ignored
    ext_bus.ext_req = 1'b1;
    acks = 0; a0 = -1;
    while (cyc < 465) begin
      step();
      if (ext_bus.ext_ack) begin acks++; if (a0 < 0) a0 = cyc; end
      if (cyc == 428) chk("resume_en_cpu", 32'(en_cpu), 32'd1);
      if (cyc == 439) ext_bus.ext_req = 1'b0;
    end
    chk("extA_acks", 32'(acks), 32'd1);
    chk("extA_ack_cyc", 32'(a0), 32'd441);

    // Copro present: windows only in phase 1 frames
    copro_en = 1'b1;
    ext_bus.ext_req = 1'b1;
    acks = 0; a0 = -1; a1 = -1;
    while (cyc < 530) begin
      step();
      if (ext_bus.ext_ack) begin
        acks++;
        if (a0 < 0) a0 = cyc; else if (a1 < 0) a1 = cyc;
      end
    end
    chk("extB_acks", 32'(acks), 32'd2);
    chk("extB_ack0_cyc", 32'(a0), 32'd489);
    chk("extB_ack1_cyc", 32'(a1), 32'd521);

    // Reset mid-window (tmr==2): immediate abort, no ack
    copro_en = 1'b0;
    while (cyc < 536) step();
    reset = 1'b1;
    #1;
    chk("rst_abort_word", 32'(ow), 32'(RST_WORD));
    chk("rst_abort_ack", 32'(ext_bus.ext_ack), 32'd0);
    acks = 0;
    repeat (3) begin
      @(posedge clk_sys); @(negedge clk_sys); #1;
      acks += int'(ext_bus.ext_ack);
    end
    chk("ack_in_reset", 32'(acks), 32'd0);
    ext_bus.ext_req = 1'b0;
    reset = 1'b0;
    cyc = 0;
    #1;
    chk("post_rst_word", 32'(ow), 32'(RST_WORD));
    acks = 0;
    repeat (20) begin
      step();
      acks += int'(ext_bus.ext_ack);
    end
    chk("ack_after_rst", 32'(acks), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
